// File: rtl/os_drain.sv
// os_drain: collects per-tile output-stationary results into a local buffer
// as each tile signals completion, then streams the array out one row per
// accepted handshake, with optional ReLU on readout and a sticky overrun flag.
module os_drain #(
  parameter  int psum_bw = 16,
  parameter  int col     = 8,
  parameter  int row     = 8,
  localparam int rbw     = $clog2(row)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [row*col-1:0]         os_ready,
  input  logic [psum_bw*row*col-1:0] os_output,
  input  logic                       relu_en,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [psum_bw*col-1:0]     out_data,
  output logic [rbw-1:0]             out_row,
  output logic                       done,
  output logic                       overrun,
  input  logic                       overrun_clr
);

  localparam int tiles = row * col;
  localparam int kbw   = (tiles > 1) ? $clog2(tiles) : 1;

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] DRAIN   = 1'b1;

  localparam logic [rbw-1:0] last_row = rbw'(row - 1);

  logic [0:0]         state;
  logic [tiles-1:0]   os_ready_d;
  logic [tiles-1:0]   rise;
  logic [tiles-1:0]   mask;
  logic [rbw-1:0]     rd_row;
  logic [psum_bw-1:0] tile_buf [tiles];
  logic               set_overrun;
  logic [kbw-1:0]     base;
  logic [psum_bw-1:0] elem;

  // A tile is reported once per low-to-high transition of its ready flag.
  assign rise = os_ready & ~os_ready_d;

  // Re-raising an already captured tile, or raising anything while the
  // buffer is being drained, means upstream got ahead of us.
  assign set_overrun = (state == COLLECT) ? |(rise & mask) : |rise;

  assign out_valid = (state == DRAIN);
  assign out_row   = rd_row;

  // Delayed copy of the ready flags for edge detection; cleared on reset so
  // flags already high after reset count as fresh completions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      os_ready_d <= '0;
    end else begin
      os_ready_d <= os_ready;
    end
  end

  // Tile buffer: captures a tile's result on its rising ready flag, but only
  // while collecting so the row being drained can never change under us.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < tiles; k++) begin
        tile_buf[k] <= '0;
      end
    end else if (state == COLLECT) begin
      for (int k = 0; k < tiles; k++) begin
        if (rise[k]) begin
          tile_buf[k] <= os_output[psum_bw*k +: psum_bw];
        end
      end
    end
  end

  // Collect/drain sequencing: enter DRAIN the edge after the mask fills,
  // advance one row per accepted handshake, pulse done after the last row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= COLLECT;
      mask   <= '0;
      rd_row <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == COLLECT) begin
        mask <= mask | rise;
        if (&mask) begin
          state  <= DRAIN;
          rd_row <= '0;
        end
      end else if (out_ready) begin
        if (rd_row == last_row) begin
          state  <= COLLECT;
          mask   <= '0;
          rd_row <= '0;
          done   <= 1'b1;
        end else begin
          rd_row <= rd_row + rbw'(1);
        end
      end
    end
  end

  // Sticky overrun flag; a new error in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (set_overrun) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  // Row readout straight from the buffer, with negative values zeroed when
  // ReLU is enabled; the bus is forced to zero while collecting.
  always_comb begin
    out_data = '0;
    elem     = '0;
    base     = kbw'(rd_row) * kbw'(col);
    if (state == DRAIN) begin
      for (int c = 0; c < col; c++) begin
        elem = tile_buf[base + kbw'(c)];
        if (relu_en && elem[psum_bw-1]) begin
          elem = '0;
        end
        out_data[psum_bw*c +: psum_bw] = elem;
      end
    end
  end

endmodule

// File: tb/tb_os_drain.sv
// tb_os_drain: directed-plus-random bench for os_drain, checking every cycle
// against a tile-level reference model of the collect/drain behaviour.
module tb_os_drain;

  localparam int PB  = 16;
  localparam int COL = 8;
  localparam int ROW = 8;
  localparam int T   = ROW * COL;

  logic              clk;
  logic              reset;
  logic [T-1:0]      os_ready;
  logic [PB*T-1:0]   os_output;
  logic              relu_en;
  logic              out_ready;
  logic              out_valid;
  logic [PB*COL-1:0] out_data;
  logic [2:0]        out_row;
  logic              done;
  logic              overrun;
  logic              overrun_clr;

  int total = 0;
  int bad   = 0;

  logic [PB-1:0] m_buf [T];
  logic [T-1:0]  m_mask;
  logic [T-1:0]  m_prev;
  bit            m_drain;
  int            m_row;
  bit            m_done;
  bit            m_ovr;

  int perm [T];

  os_drain #(.psum_bw(PB), .col(COL), .row(ROW)) dut (
    .clk         (clk),
    .reset       (reset),
    .os_ready    (os_ready),
    .os_output   (os_output),
    .relu_en     (relu_en),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_row     (out_row),
    .done        (done),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < T; k++) m_buf[k] = '0;
    m_mask  = '0;
    m_prev  = '0;
    m_drain = 1'b0;
    m_row   = 0;
    m_done  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  function automatic logic [PB*COL-1:0] expRow(input int r);
    logic [PB*COL-1:0] d;
    logic [PB-1:0]     v;
    d = '0;
    for (int c = 0; c < COL; c++) begin
      v = m_buf[r*COL + c];
      if (relu_en && v[PB-1]) v = '0;
      d[PB*c +: PB] = v;
    end
    return d;
  endfunction

  task automatic checkAllOutputs();
    checkOutput("out_valid", out_valid, m_drain);
    checkOutput("done", done, m_done);
    checkOutput("overrun", overrun, m_ovr);
    checkOutput("out_data", out_data, m_drain ? expRow(m_row) : '0);
    if (m_drain) checkOutput("out_row", out_row, m_row);
  endtask

  task automatic randomizeData();
    for (int k = 0; k < T; k++) os_output[PB*k +: PB] = PB'($urandom);
  endtask

  // Advance the model by one edge using the current inputs, clock the DUT,
  // and compare all outputs just after the edge.
  task automatic applyStimulus();
    logic [T-1:0] rise;
    bit set_ovr;
    bit full_before;
    rise    = os_ready & ~m_prev;
    m_prev  = os_ready;
    m_done  = 1'b0;
    set_ovr = 1'b0;
    if (!m_drain) begin
      full_before = (m_mask == {T{1'b1}});
      for (int k = 0; k < T; k++) begin
        if (rise[k]) begin
          if (m_mask[k]) set_ovr = 1'b1;
          m_buf[k]  = os_output[PB*k +: PB];
          m_mask[k] = 1'b1;
        end
      end
      if (full_before) begin
        m_drain = 1'b1;
        m_row   = 0;
      end
    end else begin
      if (rise != '0) set_ovr = 1'b1;
      if (out_ready) begin
        if (m_row == ROW - 1) begin
          m_drain = 1'b0;
          m_mask  = '0;
          m_row   = 0;
          m_done  = 1'b1;
        end else begin
          m_row++;
        end
      end
    end
    if (set_ovr) m_ovr = 1'b1;
    else if (overrun_clr) m_ovr = 1'b0;
    @(posedge clk);
    #1;
    checkAllOutputs();
  endtask

  task automatic lowerAll();
    os_ready = '0;
    applyStimulus();
  endtask

  // Drain the array; mode 0 keeps out_ready high, mode 1 uses 1,0,0,...
  // A non-negative stop_row leaves the drain in progress at that row.
  task automatic runDrain(input int mode, input int stop_row);
    int phase;
    int done_seen;
    int rows_q[$];
    logic [255:0] held;
    bit stalled;
    bit finished;
    phase = 0; done_seen = 0; stalled = 1'b0; finished = 1'b0; held = '0;
    for (int i = 0; i < 100 && !finished; i++) begin
      if (stop_row >= 0 && m_drain && m_row == stop_row) break;
      if (out_valid === 1'b1) begin
        if (stalled) checkOutput("stall_hold", {125'b0, out_row, out_data}, held);
        out_ready = (mode == 0) || (phase % 3 == 0);
        phase++;
        if (out_ready) rows_q.push_back(int'(out_row));
        stalled = !out_ready;
        held    = {125'b0, out_row, out_data};
      end else begin
        out_ready = 1'b0;
        stalled   = 1'b0;
      end
      randomizeData();
      applyStimulus();
      if (done === 1'b1) done_seen++;
      if (m_done) finished = 1'b1;
    end
    if (stop_row >= 0) begin
      checkOutput("stop_row_reached", out_row, stop_row);
    end else begin
      out_ready = 1'b0;
      applyStimulus();
      checkOutput("drain_finished", finished, 1'b1);
      checkOutput("done_pulses", done_seen, 1);
      checkOutput("rows_seen", rows_q.size(), ROW);
      for (int r = 0; r < rows_q.size() && r < ROW; r++) checkOutput("row_order", rows_q[r], r);
    end
  endtask

  // Directed scenario sequence.
  initial begin
    reset = 1'b1; os_ready = '0; os_output = '0; relu_en = 1'b0;
    out_ready = 1'b0; overrun_clr = 1'b0;
    modelReset();
    #1;
    checkAllOutputs();
    checkOutput("reset_row", out_row, 0);

    // All tiles at once, tile k = k+1, flags already high at reset release.
    for (int k = 0; k < T; k++) os_output[PB*k +: PB] = PB'(k + 1);
    os_ready  = '1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelReset();
    applyStimulus();
    checkOutput("a_capture_not_valid", out_valid, 1'b0);
    applyStimulus();
    checkOutput("a_row0_data", out_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    checkOutput("a_row0_idx", out_row, 0);
    runDrain(0, -1);
    checkOutput("a_no_overrun", overrun, 1'b0);

    // One tile per cycle in random order, ReLU on, stalled readout.
    lowerAll();
    relu_en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < T; i++) perm[i] = i;
    for (int i = T - 1; i > 0; i--) begin
      int j; int t;
      j = int'($urandom_range(i, 0));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < T; i++) begin
      randomizeData();
      os_ready[perm[i]] = 1'b1;
      applyStimulus();
    end
    checkOutput("b_no_valid_at_capture", out_valid, 1'b0);
    applyStimulus();
    checkOutput("b_valid_one_after", out_valid, 1'b1);
    runDrain(1, -1);

    // ReLU on a negative element.
    lowerAll();
    relu_en = 1'b1; out_ready = 1'b0;
    randomizeData();
    os_output[PB-1:0] = 16'hFFFB;
    os_ready = '1;
    applyStimulus();
    applyStimulus();
    checkOutput("c_relu_on", out_data[PB-1:0], 16'h0000);
    relu_en = 1'b0;
    #1;
    checkOutput("c_relu_off", out_data[PB-1:0], 16'hFFFB);
    runDrain(0, -1);

    // Re-raise tile 3 during drain, then clear, then set-vs-clear collision.
    lowerAll();
    out_ready = 1'b0;
    randomizeData();
    os_ready = '1;
    applyStimulus();
    applyStimulus();
    os_ready[3] = 1'b0;
    applyStimulus();
    os_ready[3] = 1'b1;
    randomizeData();
    applyStimulus();
    checkOutput("d_overrun_set", overrun, 1'b1);
    overrun_clr = 1'b1;
    applyStimulus();
    overrun_clr = 1'b0;
    checkOutput("d_overrun_clr", overrun, 1'b0);
    os_ready[3] = 1'b0;
    applyStimulus();
    os_ready[3] = 1'b1;
    overrun_clr = 1'b1;
    applyStimulus();
    overrun_clr = 1'b0;
    checkOutput("d_set_wins", overrun, 1'b1);
    runDrain(1, -1);
    overrun_clr = 1'b1;
    applyStimulus();
    overrun_clr = 1'b0;

    // Overwrite during collect, then reset in the middle of the drain.
    lowerAll();
    out_ready = 1'b0;
    randomizeData();
    os_ready = 64'h1;
    applyStimulus();
    os_ready = '0;
    applyStimulus();
    randomizeData();
    os_ready = 64'h1;
    applyStimulus();
    checkOutput("e_collect_overwrite", overrun, 1'b1);
    overrun_clr = 1'b1;
    applyStimulus();
    overrun_clr = 1'b0;
    randomizeData();
    os_ready = '1;
    applyStimulus();
    runDrain(0, 4);
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("e_abort_valid", out_valid, 1'b0);
    checkAllOutputs();
    @(posedge clk);
    #1;
    checkOutput("e_no_done", done, 1'b0);
    checkAllOutputs();
    randomizeData();
    os_ready = '1;
    reset = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("e_restart_row0", out_row, 0);
    runDrain(0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/os_drain.md
OS_DRAIN -- requirements
Module: os_drain

Interface
REQ-001 Parameter psum_bw, default 16, width of one signed tile accumulator.
REQ-002 Parameter col, default 8, tiles per array row.
REQ-003 Parameter row, default 8, array rows; rbw = $clog2(row).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 os_ready  input  row*col  per-tile accumulation-complete flags; bit k = r*col+c.
REQ-007 os_output  input  psum_bw*row*col  per-tile results; tile k occupies bits [psum_bw*(k+1)-1 : psum_bw*k].
REQ-008 relu_en  input  1  when 1, negative results read out as zero.
REQ-009 out_ready  input  1  downstream (output SRAM / FIFO) accepts a row this cycle.
REQ-010 out_valid  output  1  out_data/out_row hold a valid row.
REQ-011 out_data  output  psum_bw*col  one array row; column c at bits [psum_bw*(c+1)-1 : psum_bw*c].
REQ-012 out_row  output  rbw  index of the row on out_data.
REQ-013 done  output  1  one-cycle pulse after the last row is accepted.
REQ-014 overrun  output  1  sticky error flag.
REQ-015 overrun_clr  input  1  synchronous clear of overrun.

Function
REQ-016 The block SHALL have two states: COLLECT and DRAIN.
REQ-017 The block SHALL register os_ready into os_ready_d each cycle; rise = os_ready & ~os_ready_d.
REQ-018 In COLLECT, for each k with rise[k]=1, the block SHALL capture the tile k slice of os_output into buf[k] and set mask[k] on that clock edge.
REQ-019 A rise on a tile whose mask bit is already set in COLLECT SHALL overwrite buf[k] and SHALL set overrun.
REQ-020 When mask becomes all ones (including through captures on that same edge), the state SHALL become DRAIN on the following edge with rd_row=0.
REQ-021 In DRAIN, out_valid SHALL be 1, out_row SHALL equal rd_row, and out_data SHALL equal buf[rd_row*col +: col], with each negative element replaced by 0 when relu_en=1.
REQ-022 In COLLECT, out_valid SHALL be 0 and out_data SHALL be 0.
REQ-023 out_data/out_row SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 On out_valid & out_ready with rd_row<row-1, rd_row SHALL increment by 1.
REQ-025 On out_valid & out_ready with rd_row=row-1, the block SHALL clear mask and rd_row, return to COLLECT, and assert done for exactly the next cycle.
REQ-026 Drain throughput SHALL be one row per cycle while out_ready=1; minimum latency from final capture to first out_valid is 1 cycle.
REQ-027 Any rise during DRAIN SHALL set overrun and SHALL NOT modify buf or mask.
REQ-028 overrun SHALL be cleared by overrun_clr; if a set condition and overrun_clr coincide, set SHALL win.
REQ-029 Buffer contents SHALL be passed unmodified (signed, no saturation) apart from ReLU.

Reset
REQ-030 On reset: state=COLLECT; mask, rd_row, os_ready_d, buf all 0; out_valid, done, overrun 0; out_data 0.
REQ-031 A tile with os_ready already high at the first edge after reset release SHALL count as a rise.
REQ-032 Reset asserted mid-DRAIN SHALL abort the drain with no done pulse.

Verification
REQ-033 Raise all 64 os_ready bits in one cycle, tile k=k+1, out_ready=1 -> rows 0..7 on 8 consecutive cycles, row 0 cols 0..7 = 1..8; done pulses once; overrun=0.
REQ-034 Raise tiles one per cycle in random order -> out_valid rises exactly 1 cycle after the 64th capture; data matches per-tile values.
REQ-035 Drain with out_ready toggling 1,0,0,1... -> out_data/out_row stable during stalls; 8 rows total, in order, no duplicates.
REQ-036 Tile value -5 (0xFFFB), relu_en=1 -> element reads 0x0000; relu_en=0 -> 0xFFFB.
REQ-037 Re-raise tile 3 during DRAIN -> overrun=1, drained data unchanged; overrun_clr -> overrun=0 next cycle.
REQ-038 Assert reset during row 4 of drain -> out_valid=0 immediately, no done; the next full collect drains from row 0.
